// File: rtl/uba_intr_arb.sv
// UBA interrupt request mapper and WRU arbiter: routes device BR lines onto PI
// levels and answers CPU who-are-you cycles with a one-hot device/BR grant.
module uba_intr_arb #(
  parameter int NDEV    = 5,
  parameter int HOLDOFF = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        statPIH,
  input  logic [2:0]        statPIL,
  input  logic [4*NDEV-1:0] devINTR,
  input  logic              wruREAD,
  input  logic [2:0]        wruPI,
  output logic [6:0]        busINTR,
  output logic [4*NDEV-1:0] devACK,
  output logic              wruVALID,
  output logic              wruNONE,
  output logic [3:0]        wruDEV,
  output logic [1:0]        wruBR
);

  localparam int NB = 4 * NDEV;

  if (NDEV < 1 || NDEV > 16) begin : g_bad_ndev
    $error("uba_intr_arb: NDEV must be in 1..16");
  end
  if (HOLDOFF < 0 || HOLDOFF > 15) begin : g_bad_holdoff
    $error("uba_intr_arb: HOLDOFF must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE, ARB, ACK, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [NB-1:0]   snap_reg;
  logic [2:0]      pi_reg;
  logic [NB-1:0]   win_reg;
  logic            win_found_reg;
  logic [3:0]      win_dev_reg;
  logic [1:0]      win_br_reg;

  logic [NB-1:0]   mask;
  logic [NB-1:0]   eff;
  logic [NDEV-1:0] hi_vec;
  logic [NDEV-1:0] lo_vec;
  logic [6:0]      bus_next;

  logic            arb_found;
  logic [3:0]      arb_dev;
  logic [1:0]      arb_br;
  logic [NB-1:0]   arb_onehot;

  // Only the granted device/BR is blocked, and only while holding off.
  assign mask = (state_reg == HOLD) ? win_reg : '0;
  assign eff  = devINTR & ~mask;

  for (genvar gi = 0; gi < NDEV; gi++) begin : g_dev
    assign hi_vec[gi] = eff[4*gi+3] | eff[4*gi+2];
    assign lo_vec[gi] = eff[4*gi+1] | eff[4*gi+0];
  end

  // bit 6 is PI1, bit 0 is PI7; level 0 means the group is disabled
  always_comb begin
    bus_next = '0;
    if (statPIH != 3'd0 && |hi_vec) bus_next[3'd7 - statPIH] = 1'b1;
    if (statPIL != 3'd0 && |lo_vec) bus_next[3'd7 - statPIL] = 1'b1;
  end

  // Highest BR wins; within a BR the lowest device index wins.
  always_comb begin
    arb_found  = 1'b0;
    arb_dev    = '0;
    arb_br     = '0;
    arb_onehot = '0;
    if (pi_reg != 3'd0) begin
      for (int b = 3; b >= 0; b--) begin
        for (int d = 0; d < NDEV; d++) begin
          if (!arb_found && snap_reg[4*d+b] &&
              (((b >= 2) ? statPIH : statPIL) == pi_reg)) begin
            arb_found           = 1'b1;
            arb_dev             = 4'(d);
            arb_br              = 2'(b);
            arb_onehot[4*d+b]   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (wruREAD) state_next = ARB;
      ARB:  state_next = ACK;
      ACK: begin
        if (win_found_reg && HOLDOFF != 0) begin
          state_next = HOLD;
          cnt_next   = 4'(HOLDOFF);
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (cnt_reg <= 4'd1) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_reg      <= '0;
      pi_reg        <= '0;
      win_reg       <= '0;
      win_found_reg <= 1'b0;
      win_dev_reg   <= '0;
      win_br_reg    <= '0;
      busINTR       <= '0;
      devACK        <= '0;
      wruVALID      <= 1'b0;
      wruNONE       <= 1'b0;
      wruDEV        <= '0;
      wruBR         <= '0;
    end else begin
      busINTR  <= bus_next;
      devACK   <= '0;
      wruVALID <= 1'b0;
      wruNONE  <= 1'b0;
      wruDEV   <= '0;
      wruBR    <= '0;
      if (state_reg == IDLE && wruREAD) begin
        snap_reg <= eff;
        pi_reg   <= wruPI;
      end
      if (state_reg == ARB) begin
        win_reg       <= arb_onehot;
        win_found_reg <= arb_found;
        win_dev_reg   <= arb_dev;
        win_br_reg    <= arb_br;
      end
      if (state_reg == ACK) begin
        wruVALID <= 1'b1;
        wruNONE  <= ~win_found_reg;
        if (win_found_reg) begin
          devACK <= win_reg;
          wruDEV <= win_dev_reg;
          wruBR  <= win_br_reg;
        end
      end
    end
  end

endmodule
